// File: rtl/rv32_mem_pkg.sv
// Shared request bundle between the RV32 core and its data-side responders.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        mem_op_t     op;
        mem_size_t   size;
    } memory_request_t;

endpackage

// File: rtl/rv32_data_responder.sv
// Data-side responder: word RAM with byte enables, fixed wait states,
// and a 64-bit mtime/mtimecmp timer window driving mtip.
module rv32_data_responder
    import rv32_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic            clk,
    input  logic            resetn,
    input  memory_request_t data_request,
    output logic            data_request_done,
    output logic [31:0]     data,
    output logic            mtip
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [3:0] WS_INIT =
        4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    mem_op_t     op_q, op_d;
    mem_size_t   size_q, size_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        mtip_q, mtip_d;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        idle;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    mem_op_t     e_op;
    mem_size_t   e_size;
    logic        commit;
    logic        e_ram;
    logic        e_mmio;
    logic        misaligned;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic        ram_we;
    logic        mmio_we;
    logic        q_ram;
    logic        q_mmio;

    // In IDLE the live request is the one being accepted; afterwards
    // only the latched copy matters.
    assign idle    = (state_q == S_IDLE);
    assign e_addr  = idle ? data_request.addr : addr_q;
    assign e_wdata = idle ? data_request.data : wdata_q;
    assign e_op    = idle ? data_request.op   : op_q;
    assign e_size  = idle ? data_request.size : size_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        size_d  = size_q;
        unique case (state_q)
            S_IDLE: begin
                if (data_request.op != MEM_NONE) begin
                    addr_d  = data_request.addr;
                    wdata_d = data_request.data;
                    op_d    = data_request.op;
                    size_d  = data_request.size;
                    if (WAIT_STATES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every transition into DONE is the commit edge (DONE never self-loops).
    assign commit = (state_d == S_DONE);

    assign e_ram  = (e_addr[31:2] < DEPTH_L);
    assign e_mmio = (e_addr[31:4] == MMIO_BASE[31:4]) && !e_ram;
    assign misaligned = ((e_size == HALF) && e_addr[0]) ||
                        ((e_size == WORD) && (e_addr[1:0] != 2'b00));

    always_comb begin
        be = 4'b0000;
        case (e_size)
            BYTE:    be = 4'b0001 << e_addr[1:0];
            HALF:    be = 4'b0011 << e_addr[1:0];
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign wlane   = e_wdata << {e_addr[1:0], 3'b000};
    assign ram_we  = commit && (e_op == MEM_WRITE) && e_ram && !misaligned;
    assign mmio_we = commit && (e_op == MEM_WRITE) && e_mmio &&
                     (e_size == WORD) && !misaligned;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[e_addr[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
        if (commit) rdata_q <= mem[e_addr[AW+1:2]];
    end

    // A timer write takes the place of that cycle's increment.
    always_comb begin
        mtime_d = mtime_q + 64'd1;
        cmp_d   = cmp_q;
        if (mmio_we) begin
            case (e_addr[3:2])
                2'd0:    mtime_d = {mtime_q[63:32], e_wdata};
                2'd1:    mtime_d = {e_wdata, mtime_q[31:0]};
                2'd2:    cmp_d   = {cmp_q[63:32], e_wdata};
                default: cmp_d   = {e_wdata, cmp_q[31:0]};
            endcase
        end
        mtip_d = (mtime_q >= cmp_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            op_q    <= MEM_NONE;
            size_q  <= BYTE;
            mtime_q <= 64'h0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            size_q  <= size_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            mtip_q  <= mtip_d;
        end
    end

    assign q_ram  = (addr_q[31:2] < DEPTH_L);
    assign q_mmio = (addr_q[31:4] == MMIO_BASE[31:4]) && !q_ram;

    always_comb begin
        data = 32'h0;
        if ((state_q == S_DONE) && (op_q == MEM_READ)) begin
            if (q_ram) begin
                data = rdata_q;
            end else if (q_mmio) begin
                case (addr_q[3:2])
                    2'd0:    data = mtime_q[31:0];
                    2'd1:    data = mtime_q[63:32];
                    2'd2:    data = cmp_q[31:0];
                    default: data = cmp_q[63:32];
                endcase
            end
        end
    end

    assign data_request_done = (state_q == S_DONE);
    assign mtip              = mtip_q;

endmodule

// File: tb/tb_rv32_data_responder.sv
// Bench for rv32_data_responder: directed scenarios plus randomized
// RAM traffic checked against a byte-addressed memory model.
module tb_rv32_data_responder;
    import rv32_mem_pkg::*;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    memory_request_t req, req0;
    logic done, done0, mtip, mtip0;
    logic [31:0] data, data0;
    int n_tests = 0;
    int n_fail = 0;
    int ecount = 0;
    logic [7:0] mm [1024];

    always #5 clk = ~clk;

    // Rising edges seen since reset released: the ideal free-running mtime.
    always @(posedge clk or negedge resetn)
        if (!resetn) ecount <= 0;
        else         ecount <= ecount + 1;

    rv32_data_responder #(
        .DEPTH_WORDS(256), .WAIT_STATES(2), .MMIO_BASE(MB)
    ) dut (
        .clk(clk), .resetn(resetn), .data_request(req),
        .data_request_done(done), .data(data), .mtip(mtip)
    );

    rv32_data_responder #(
        .DEPTH_WORDS(256), .WAIT_STATES(0), .MMIO_BASE(MB)
    ) dut0 (
        .clk(clk), .resetn(resetn), .data_request(req0),
        .data_request_done(done0), .data(data0), .mtip(mtip0)
    );

    // Issue one request; return at the negedge inside the done cycle.
    task automatic do_req(input bit w0, input mem_op_t op,
                          input mem_size_t sz, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        memory_request_t r;
        r.addr = a; r.data = wd; r.op = op; r.size = sz;
        @(negedge clk);
        if (w0) req0 = r; else req = r;
        @(posedge clk);
        @(negedge clk);
        if (w0) req0.op = MEM_NONE; else req.op = MEM_NONE;
        lat = -1;
        rd = 32'h0;
        for (int n = 1; n <= 20; n++) begin
            if (w0 ? done0 : done) begin
                lat = n;
                rd = w0 ? data0 : data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        req = '0;
        req0 = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({done, done0, mtip, mtip0} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 0000",
                     {done, done0, mtip, mtip0});
        end
        n_tests++;
        if (data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", data);
        end
        resetn = 1'b1;
        do_req(0, MEM_READ, WORD, MB + 32'h8, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'hFFFF_FFFF || lat != 3) begin
            n_fail++;
            $display("FAIL reset_cmp_lo got %h lat %0d want ffffffff lat 3",
                     rd, lat);
        end
        do_req(0, MEM_READ, WORD, MB + 32'hC, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_cmp_hi got %h want ffffffff", rd);
        end
        do_req(0, MEM_READ, WORD, MB, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'(ecount)) begin
            n_fail++;
            $display("FAIL reset_mtime got %0d want %0d", rd, ecount);
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd;
        int lat;
        do_req(0, MEM_WRITE, WORD, 32'h100, 32'hDEAD_BEEF, rd, lat);
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL wr_latency got %0d want 3", lat);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle got %b want 0", done);
        end
        do_req(0, MEM_READ, WORD, 32'h100, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF || lat != 3) begin
            n_fail++;
            $display("FAIL rd_word got %h lat %0d want deadbeef lat 3",
                     rd, lat);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        int lat;
        do_req(0, MEM_WRITE, WORD, 32'h200, 32'h0, rd, lat);
        do_req(0, MEM_WRITE, BYTE, 32'h203, 32'h0000_00AA, rd, lat);
        do_req(0, MEM_WRITE, HALF, 32'h200, 32'h0000_1234, rd, lat);
        do_req(0, MEM_READ, WORD, 32'h200, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'hAA00_1234) begin
            n_fail++;
            $display("FAIL byte_half got %h want aa001234", rd);
        end
    endtask

    task automatic test_misaligned_unmapped();
        logic [31:0] rd;
        int lat;
        do_req(0, MEM_WRITE, WORD, 32'h102, 32'h1111_1111, rd, lat);
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL misal_done got lat %0d want 3", lat);
        end
        do_req(0, MEM_WRITE, HALF, 32'h101, 32'h0000_FFFF, rd, lat);
        do_req(0, MEM_READ, WORD, 32'h100, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL misal_keep got %h want deadbeef", rd);
        end
        do_req(0, MEM_READ, WORD, 32'h400, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'h0 || lat != 3) begin
            n_fail++;
            $display("FAIL unmapped_rd got %h lat %0d want 0 lat 3", rd, lat);
        end
        do_req(0, MEM_WRITE, WORD, 32'h8000_0000, 32'h5555_5555, rd, lat);
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL unmapped_wr got lat %0d want 3", lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, a, exp;
        int lat, nb;
        mem_op_t op;
        mem_size_t sz;
        bit ok;
        for (int w = 16; w < 48; w++) begin
            wd = $urandom;
            a = 32'(w * 4);
            for (int k = 0; k < 4; k++) mm[a + 32'(k)] = wd[8*k +: 8];
            do_req(0, MEM_WRITE, WORD, a, wd, rd, lat);
        end
        for (int i = 0; i < 60; i++) begin
            a = 32'h40 + 32'($urandom_range(0, 127));
            wd = $urandom;
            sz = mem_size_t'($urandom_range(0, 2));
            op = ($urandom_range(0, 1) == 0) ? MEM_READ : MEM_WRITE;
            do_req(0, op, sz, a, wd, rd, lat);
            if (op == MEM_WRITE) begin
                nb = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
                ok = (a % nb) == 0;
                if (ok)
                    for (int k = 0; k < nb; k++)
                        mm[a + 32'(k)] = wd[8*k +: 8];
                n_tests++;
                if (lat != 3) begin
                    n_fail++;
                    $display("FAIL rand_wr_lat addr %h got %0d want 3",
                             a, lat);
                end
            end else begin
                a = a & ~32'h3;
                exp = {mm[a + 3], mm[a + 2], mm[a + 1], mm[a]};
                n_tests++;
                if (rd !== exp || lat != 3) begin
                    n_fail++;
                    $display("FAIL rand_rd addr %h got %h lat %0d want %h",
                             a, rd, lat, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        bit saw;
        do_req(0, MEM_WRITE, WORD, 32'h300, 32'h5A5A_1234, rd, lat);
        @(negedge clk);
        req = '{addr: 32'h300, data: 32'hFFFF_FFFF,
                op: MEM_WRITE, size: WORD};
        @(posedge clk);
        @(negedge clk);
        req.op = MEM_NONE;
        resetn = 1'b0;
        saw = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        n_tests++;
        if (saw) begin
            n_fail++;
            $display("FAIL cut_done got pulse want none");
        end
        do_req(0, MEM_READ, WORD, MB, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'(ecount)) begin
            n_fail++;
            $display("FAIL cut_mtime got %0d want %0d", rd, ecount);
        end
        do_req(0, MEM_READ, WORD, 32'h300, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'h5A5A_1234) begin
            n_fail++;
            $display("FAIL cut_mem got %h want 5a5a1234", rd);
        end
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        int lat;
        logic exp;
        bit rose;
        apply_reset();
        do_req(0, MEM_WRITE, WORD, MB + 32'hC, 32'h0, rd, lat);
        do_req(0, MEM_WRITE, WORD, MB + 32'h8, 32'd50, rd, lat);
        rose = 1'b0;
        for (int i = 0; i < 80 && ecount < 60; i++) begin
            @(negedge clk);
            exp = (ecount - 1 >= 50);
            if (mtip) rose = 1'b1;
            n_tests++;
            if (mtip !== exp) begin
                n_fail++;
                $display("FAIL mtip mtime %0d got %b want %b",
                         ecount, mtip, exp);
            end
        end
        n_tests++;
        if (!rose) begin
            n_fail++;
            $display("FAIL mtip_rise got none want rise");
        end
        do_req(0, MEM_WRITE, WORD, MB + 32'hC, 32'hFFFF_FFFF, rd, lat);
        n_tests++;
        if (mtip !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_same got %b want 1", mtip);
        end
        @(negedge clk);
        n_tests++;
        if (mtip !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_fall got %b want 0", mtip);
        end
    endtask

    task automatic test_mtime_write();
        logic [31:0] rd;
        int lat, c1;
        do_req(0, MEM_WRITE, WORD, MB + 32'h4, 32'd5, rd, lat);
        do_req(0, MEM_WRITE, WORD, MB, 32'd100, rd, lat);
        c1 = ecount;
        do_req(0, MEM_READ, WORD, MB, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'(100 + ecount - c1)) begin
            n_fail++;
            $display("FAIL mtime_lo got %0d want %0d", rd, 100 + ecount - c1);
        end
        do_req(0, MEM_READ, WORD, MB + 32'h4, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'd5) begin
            n_fail++;
            $display("FAIL mtime_hi got %0d want 5", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        logic exp;
        do_req(1, MEM_WRITE, WORD, 32'h10, 32'hCAFE_F00D, rd, lat);
        n_tests++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL ws0_wr_lat got %0d want 1", lat);
        end
        do_req(1, MEM_READ, WORD, 32'h10, 32'h0, rd, lat);
        n_tests++;
        if (rd !== 32'hCAFE_F00D || lat != 1) begin
            n_fail++;
            $display("FAIL ws0_rd got %h lat %0d want cafef00d lat 1",
                     rd, lat);
        end
        @(negedge clk);
        req0 = '{addr: 32'h10, data: 32'h0, op: MEM_READ, size: WORD};
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            exp = (n % 2) == 1;
            n_tests++;
            if (done0 !== exp || (exp && data0 !== 32'hCAFE_F00D)) begin
                n_fail++;
                $display("FAIL b2b cycle %0d got %b/%h want %b/cafef00d",
                         n, done0, data0, exp);
            end
        end
        req0.op = MEM_NONE;
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_misaligned_unmapped();
        test_random();
        test_reset_mid();
        test_timer();
        test_mtime_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_data_responder.md
RV32_DATA_RESPONDER -- requirements
Module: rv32_data_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: backing RAM size in 32-bit words; power of two, at least 16.
REQ-002 Parameter WAIT_STATES, default 2: extra cycles before completion; legal range 0..15.
REQ-003 Parameter MMIO_BASE, default 32'hFFFF_0000: base of the 16-byte timer window; 16-byte aligned.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port resetn  input  1  reset; asynchronous and active-low.
REQ-006 Port data_request  input  memory_request_t  core request; fields used: addr[31:0], data[31:0] (write data), op (MEM_NONE/MEM_READ/MEM_WRITE), size (BYTE/HALF/WORD).
REQ-007 Port data_request_done  output  1  one-cycle completion pulse.
REQ-008 Port data  output  32  read word; valid only while data_request_done=1.
REQ-009 Port mtip  output  1  machine timer interrupt pending, registered.

Function
REQ-010 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-011 IDLE: op!=MEM_NONE at a rising edge latches addr, data, op and size; next state WAIT if WAIT_STATES>0, else DONE. Otherwise stay in IDLE.
REQ-012 WAIT: a 4-bit counter loads WAIT_STATES-1 on entry and decrements each cycle; the state moves to DONE on the edge where the counter is 0.
REQ-013 DONE: data_request_done=1 for exactly this cycle; unconditional transition to IDLE; the request present during DONE is not sampled.
REQ-014 Latency from the accepting edge to the done cycle is WAIT_STATES+1 cycles; minimum issue-to-issue spacing is WAIT_STATES+2 cycles.
REQ-015 Request inputs are ignored outside IDLE; only latched values are used.
REQ-016 Address decode on latched addr: RAM when addr[31:2] < DEPTH_WORDS; MMIO when addr[31:4]==MMIO_BASE[31:4]; all other addresses are unmapped.
REQ-017 RAM read: data = RAM[addr[31:2]], full word with no byte extraction; the core performs extraction and sign extension.
REQ-018 RAM write is committed on the edge entering DONE, using byte enables:
- BYTE: 1 << addr[1:0]
- HALF: 4'b0011 << addr[1:0]
- WORD: 4'b1111
REQ-019 Write lane alignment: write data bytes are taken from lanes aligned to addr[1:0], i.e. wdata is shifted left by 8*addr[1:0].
REQ-020 Misaligned writes are dropped with no memory or MMIO change, but done still pulses: HALF with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-021 Unmapped read returns 32'h0; unmapped write is dropped; done pulses normally in both cases.
REQ-022 When not in DONE, data=32'h0.
REQ-023 MMIO map, word access only (non-WORD MMIO writes dropped):
- +0x0 mtime[31:0]
- +0x4 mtime[63:32]
- +0x8 mtimecmp[31:0]
- +0xC mtimecmp[63:32]
REQ-024 mtime is a 64-bit counter, +1 every cycle, wrapping from all-ones to 0.
REQ-025 A write to mtime replaces the addressed half in place of that cycle's increment.
REQ-026 MMIO reads return the value registered at the start of the DONE cycle.
REQ-027 mtip is registered each cycle as (mtime >= mtimecmp), unsigned 64-bit compare, so it lags the counter by one cycle.
REQ-028 Simultaneous mtimecmp write and compare: the compare uses the pre-write value; the new value affects mtip from the next cycle.

Reset
REQ-029 Asserting resetn=0 at any time, including mid-transaction, forces:
- state=IDLE, counter=0
- data_request_done=0, data=0
- mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtip=0
REQ-030 A transaction cut by reset never pulses done; its pending write is not committed.
REQ-031 RAM contents are not reset.
REQ-032 The first request is accepted on the first rising edge after resetn returns to 1.

Verification
REQ-033 WAIT_STATES=2: WORD write 32'hDEADBEEF to 0x100, then WORD read 0x100 -> each done pulse occurs exactly 3 cycles after acceptance; read data=32'hDEADBEEF.
REQ-034 Over a word holding 32'h0: BYTE write 0xAA to 0x203, then HALF write 0x1234 to 0x200 -> read 0x200 returns 32'hAA00_1234.
REQ-035 Misaligned and unmapped accesses:
- WORD write to 0x102 -> word 0x100 unchanged, done still pulses.
- Read of DEPTH_WORDS*4 -> data=0.
REQ-036 Timer interrupt: write mtimecmp hi=0, lo=50 -> mtip rises in the cycle after mtime reaches 50.
REQ-037 Timer rearm: write mtimecmp hi=all-ones -> mtip falls the next cycle.
REQ-038 Reset mid-operation: assert resetn=0 during WAIT of a write to 0x300 -> no done pulse, 0x300 unchanged, mtime reads 0 plus the elapsed cycles after release.
REQ-039 WAIT_STATES=0: back-to-back requests -> done every 2nd cycle with latency 1.
